d2_report_tx: RTL and testbench

//  Serialises binary report levels into the ASCII day-2 stream format: decimal values, ' ' between values, '\n' per report.

---
 rtl/d2_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 48 ++++
 rtl/d2_report_tx.sv | 176 +++++++++++++++++
 tb/tb_d2_report_tx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d2_pkg.sv
// Shared constants, state encoding and ASCII helper for the day-2 report serialiser.
package d2_pkg;
   localparam logic [7:0] CHR_SPACE = 8'h20;
   localparam logic [7:0] CHR_NL    = 8'h0A;
   localparam logic [7:0] CHR_ZERO  = 8'h30;

   typedef enum logic [2:0] {
      IDLE,
      EMIT_SP,
      CONV,
      EMIT_DIG,
      EMIT_NL,
      DONE
   } tx_state_t;

   function automatic logic [7:0] ascii_digit(input logic [3:0] d);
      return CHR_ZERO + {4'h0, d};
   endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: loads on start, then runs VAL_W shift-add-3 steps.
module bin2bcd_seq #(
   parameter int VAL_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [VAL_W-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd
);
   localparam int CNT_W = $clog2(VAL_W + 1);

   logic [VAL_W-1:0]    shift;
   logic [CNT_W-1:0]    cnt;
   logic [DIGITS*4-1:0] bcd_adj;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] > 4'd4) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   // done marks the edge that performs the final step; bcd is settled after it
   assign done = busy && (cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         cnt   <= '0;
         shift <= '0;
         bcd   <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         cnt   <= CNT_W'(VAL_W);
         shift <= value;
         bcd   <= '0;
      end else if (busy) begin
         bcd   <= {bcd_adj[DIGITS*4-2:0], shift[VAL_W-1]};
         shift <= shift << 1;
         cnt   <= cnt - CNT_W'(1);
         if (done) busy <= 1'b0;
      end
   end
endmodule

// File: rtl/d2_report_tx.sv
// Serialises report levels into ASCII: decimal values, ' ' separators, '\n' per report.
//  state    | meaning
//  IDLE     | waiting for a level or stream_end
//  EMIT_SP  | presenting the ' ' separator
//  CONV     | binary-to-BCD conversion running
//  EMIT_DIG | presenting decimal digits, most significant first
//  EMIT_NL  | presenting the '\n' report terminator
//  DONE     | stream finished, terminal until reset
module d2_report_tx
   import d2_pkg::*;
#(
   parameter int VAL_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [VAL_W-1:0]  level_in,
   input  logic              level_last,
   input  logic              level_valid,
   output logic              level_ready,
   input  logic              stream_end,
   output logic [7:0]        byte_out,
   output logic              byte_out_valid,
   input  logic              byte_out_ready,
   output logic              bytes_done,
   output logic [15:0]       report_count,
   output logic [31:0]       byte_count
);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   tx_state_t           state, state_d;
   logic                mid_report, mid_d;
   logic [VAL_W-1:0]    value_q, value_d;
   logic                last_q, last_d;
   logic                from_end, from_end_d;
   logic [IDX_W-1:0]    dig_idx, idx_d, lz_idx;
   logic [7:0]          byte_d;
   logic                valid_d;
   logic                xfer;
   logic                conv_start, conv_busy, conv_done;
   logic [VAL_W-1:0]    conv_value;
   logic [DIGITS*4-1:0] bcd;

   bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .value (conv_value),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (bcd)
   );

   assign xfer        = byte_out_valid && byte_out_ready;
   assign level_ready = (state == IDLE) && rst_n;
   assign bytes_done  = (state == DONE);
   assign conv_value  = (state == IDLE) ? level_in : value_q;

   // Most significant non-zero digit; stays 0 for value 0 so a single '0' is emitted
   always_comb begin
      lz_idx = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[i*4 +: 4] != 4'd0) lz_idx = IDX_W'(i);
      end
   end

   always_comb begin
      state_d    = state;
      mid_d      = mid_report;
      value_d    = value_q;
      last_d     = last_q;
      from_end_d = from_end;
      idx_d      = dig_idx;
      byte_d     = byte_out;
      valid_d    = byte_out_valid;
      conv_start = 1'b0;
      case (state)
         IDLE: begin
            if (level_valid) begin
               value_d = level_in;
               last_d  = level_last;
               if (mid_report) begin
                  state_d = EMIT_SP;
                  byte_d  = CHR_SPACE;
                  valid_d = 1'b1;
               end else begin
                  state_d    = CONV;
                  conv_start = 1'b1;
               end
            end else if (stream_end) begin
               if (mid_report) begin
                  state_d    = EMIT_NL;
                  byte_d     = CHR_NL;
                  valid_d    = 1'b1;
                  from_end_d = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         EMIT_SP: begin
            if (xfer) begin
               state_d    = CONV;
               valid_d    = 1'b0;
               conv_start = 1'b1;
            end
         end
         CONV: begin
            if (conv_done) state_d = EMIT_DIG;
         end
         EMIT_DIG: begin
            // First cycle here loads the leading digit once bcd has settled
            if (!byte_out_valid && !conv_busy) begin
               idx_d   = lz_idx;
               byte_d  = ascii_digit(bcd[lz_idx*4 +: 4]);
               valid_d = 1'b1;
            end else if (xfer) begin
               if (dig_idx == '0) begin
                  if (last_q) begin
                     state_d    = EMIT_NL;
                     byte_d     = CHR_NL;
                     from_end_d = 1'b0;
                  end else begin
                     state_d = IDLE;
                     valid_d = 1'b0;
                     mid_d   = 1'b1;
                  end
               end else begin
                  idx_d  = dig_idx - IDX_W'(1);
                  byte_d = ascii_digit(bcd[idx_d*4 +: 4]);
               end
            end
         end
         EMIT_NL: begin
            if (xfer) begin
               valid_d = 1'b0;
               mid_d   = 1'b0;
               state_d = from_end ? DONE : IDLE;
            end
         end
         DONE: begin
            valid_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         mid_report     <= 1'b0;
         value_q        <= '0;
         last_q         <= 1'b0;
         from_end       <= 1'b0;
         dig_idx        <= '0;
         byte_out       <= 8'h00;
         byte_out_valid <= 1'b0;
         report_count   <= 16'd0;
         byte_count     <= 32'd0;
      end else begin
         state          <= state_d;
         mid_report     <= mid_d;
         value_q        <= value_d;
         last_q         <= last_d;
         from_end       <= from_end_d;
         dig_idx        <= idx_d;
         byte_out       <= byte_d;
         byte_out_valid <= valid_d;
         if (xfer) byte_count <= byte_count + 32'd1;
         if (xfer && (state == EMIT_NL)) report_count <= report_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_d2_report_tx.sv
// Bench for d2_report_tx: a byte-queue model of the ASCII report format, checked every cycle.
module tb_d2_report_tx;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  level_in = 8'd0;
   logic        level_last = 1'b0;
   logic        level_valid = 1'b0;
   logic        level_ready;
   logic        stream_end = 1'b0;
   logic [7:0]  byte_out;
   logic        byte_out_valid;
   logic        byte_out_ready = 1'b1;
   logic        bytes_done;
   logic [15:0] report_count;
   logic [31:0] byte_count;

   d2_report_tx #(.VAL_W(8), .DIGITS(3)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .level_in       (level_in),
      .level_last     (level_last),
      .level_valid    (level_valid),
      .level_ready    (level_ready),
      .stream_end     (stream_end),
      .byte_out       (byte_out),
      .byte_out_valid (byte_out_valid),
      .byte_out_ready (byte_out_ready),
      .bytes_done     (bytes_done),
      .report_count   (report_count),
      .byte_count     (byte_count)
   );

   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];
   int         exp_bytes = 0;
   int         exp_reports = 0;
   bit         model_mid = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_byte = 8'h00;
   int         sink_mode = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Model of the text format: what a level contributes to the byte stream
   task automatic model_level(input logic [7:0] v, input bit last);
      string s;
      if (model_mid) exp_q.push_back(8'h20);
      s = $sformatf("%0d", v);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
      if (last) begin
         exp_q.push_back(8'h0A);
         model_mid = 1'b0;
      end else begin
         model_mid = 1'b1;
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      exp_bytes   = 0;
      exp_reports = 0;
      model_mid   = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
         0:       byte_out_ready = 1'b1;
         1:       byte_out_ready = ~byte_out_ready;
         default: byte_out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Compare process: counters, stall stability and every transferred byte
   initial forever begin
      logic [7:0] e;
      @(negedge clk);
      if (!rst_n) begin
         prev_stall = 1'b0;
         continue;
      end
      chk("byte_count", byte_count, exp_bytes);
      chk("report_count", 32'(report_count), exp_reports);
      if (prev_stall) begin
         chk("stall_valid", 32'(byte_out_valid), 1);
         chk("stall_byte", 32'(byte_out), 32'(prev_byte));
      end
      if (byte_out_valid && byte_out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got 0x%0h expected no byte", byte_out);
         end else begin
            e = exp_q.pop_front();
            chk("stream_byte", 32'(byte_out), 32'(e));
            exp_bytes++;
            if (e == 8'h0A) exp_reports++;
         end
      end
      prev_stall = byte_out_valid && !byte_out_ready;
      prev_byte  = byte_out;
   end

   task automatic do_reset(input int cycles);
      rst_n       = 1'b0;
      level_valid = 1'b0;
      stream_end  = 1'b0;
      model_clear();
      repeat (cycles) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic send_level(input logic [7:0] v, input bit last);
      bit ok = 1'b0;
      level_in    = v;
      level_last  = last;
      level_valid = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (level_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1 level_valid = 1'b0;
      if (ok) model_level(v, last);
      else chk("level_accept_timeout", 0, 1);
   endtask

   task automatic end_stream();
      bit ok = 1'b0;
      stream_end = 1'b1;
      if (model_mid) exp_q.push_back(8'h0A);
      model_mid = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (bytes_done) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1 stream_end = 1'b0;
      if (!ok) chk("bytes_done_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      bit ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !byte_out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!ok) chk("drain_timeout", 32'(exp_q.size()), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int k;
      logic [7:0] edge_vals[6];
      edge_vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_level_ready", 32'(level_ready), 0);
      chk("reset_valid", 32'(byte_out_valid), 0);
      chk("reset_byte", 32'(byte_out), 0);
      chk("reset_done", 32'(bytes_done), 0);
      chk("reset_bytes", byte_count, 0);
      chk("reset_reports", 32'(report_count), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_level_ready", 32'(level_ready), 1);
      @(posedge clk);
      #1;

      // 1: "7 6 4 2 1\n" with latency checks
      sink_mode = 0;
      send_level(8'd7, 1'b0);
      k = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1 k++;
         if (byte_out_valid) break;
      end
      chk("first_digit_latency", k, 9);
      send_level(8'd6, 1'b0);
      chk("space_latency_valid", 32'(byte_out_valid), 1);
      chk("space_latency_byte", 32'(byte_out), 32'h20);
      send_level(8'd4, 1'b0);
      send_level(8'd2, 1'b0);
      send_level(8'd1, 1'b1);
      wait_drain();
      chk("t1_report_count", 32'(report_count), 1);
      chk("t1_byte_count", byte_count, 10);

      // 2: "0 255\n" then sticky done
      do_reset(2);
      send_level(8'd0, 1'b0);
      send_level(8'd255, 1'b1);
      end_stream();
      chk("t2_done", 32'(bytes_done), 1);
      chk("t2_level_ready", 32'(level_ready), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("t2_done_sticky", 32'(bytes_done), 1);
      chk("t2_valid_low", 32'(byte_out_valid), 0);
      chk("t2_byte_count", byte_count, 6);

      // 3: "100\n" flushed by stream_end
      do_reset(2);
      send_level(8'd100, 1'b0);
      end_stream();
      chk("t3_done", 32'(bytes_done), 1);
      chk("t3_report_count", 32'(report_count), 1);
      chk("t3_byte_count", byte_count, 4);

      // 4: alternating backpressure on "123\n"
      do_reset(2);
      sink_mode = 1;
      send_level(8'd123, 1'b1);
      wait_drain();
      chk("t4_byte_count", byte_count, 4);
      sink_mode = 0;

      // 5: reset during the second digit of 45
      do_reset(2);
      send_level(8'd45, 1'b1);
      k = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (byte_out_valid && byte_out == 8'h35) begin
            k = 1;
            break;
         end
      end
      chk("t5_saw_second_digit", k, 1);
      rst_n = 1'b0;
      model_clear();
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("t5_valid_after_reset", 32'(byte_out_valid), 0);
      chk("t5_bytes_after_reset", byte_count, 0);
      chk("t5_reports_after_reset", 32'(report_count), 0);
      send_level(8'd9, 1'b1);
      wait_drain();
      chk("t5_byte_count", byte_count, 2);

      // 6: level and stream_end together -> "55\n"
      do_reset(2);
      stream_end = 1'b1;
      send_level(8'd55, 1'b0);
      end_stream();
      chk("t6_done", 32'(bytes_done), 1);
      chk("t6_byte_count", byte_count, 3);

      // 7: random reports under random backpressure, including boundary values
      do_reset(2);
      sink_mode = 2;
      for (int i = 0; i < 6; i++) send_level(edge_vals[i], i == 5);
      for (int r = 0; r < 8; r++) begin
         int n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_level(8'($urandom_range(0, 255)), i == n - 1);
         end
      end
      send_level(8'($urandom_range(0, 255)), 1'b0);
      end_stream();
      chk("t7_done", 32'(bytes_done), 1);
      chk("t7_queue_empty", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
